// File: rtl/trace_ctrl_pkg.sv
// trace_ctrl_pkg: shared types and helpers for the trace capture sequencer.
// Holds the capture state enum, the trace depth legality check and the
// masked trigger-match function used by trace_trig_match.
package trace_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest trigger bus the match helper handles; callers zero-extend.
  localparam int MATCH_W = 32;

  // Trace depth must be a power of two so the write pointer wraps for free.
  function automatic bit depth_ok(int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  // Mask bit 1 = compare, 0 = don't care. A disabled bus never matches.
  function automatic logic masked_match(logic en, logic [MATCH_W-1:0] din,
                                        logic [MATCH_W-1:0] value,
                                        logic [MATCH_W-1:0] mask);
    return en && (((din ^ value) & mask) == '0);
  endfunction

endpackage

// File: rtl/trace_trig_match.sv
// trace_trig_match: masked trigger comparator producing a single fire bit.
// Build option TRACE_CAPTURE_CTRL_EDGE_EN: fire only on a rising match
// (match now, none last cycle); otherwise fire on every matching cycle.
module trace_trig_match
  import trace_ctrl_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              trigger_en,
  input  logic [DATA_W-1:0] trigger_din,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  output logic              fire
);

  logic match;

  assign match = masked_match(trigger_en, MATCH_W'(trigger_din),
                              MATCH_W'(trig_value), MATCH_W'(trig_mask));

`ifdef TRACE_CAPTURE_CTRL_EDGE_EN
  logic prev_match;

  // Remember last cycle's match for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) prev_match <= 1'b0;
    else       prev_match <= match;
  end

  // The arm cycle ignores history, so a level already present at arm fires.
  assign fire = match && (restart || !prev_match);
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, restart};
  assign fire      = match;
`endif

endmodule

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: logic-analyzer capture sequencer. Streams trace_din
// into a circular trace RAM while armed, latches the trigger address on a
// masked match, writes post_count more samples, then stops with RAM stable.
// Build option TRACE_CAPTURE_CTRL_EDGE_EN selects rising-edge triggering.
module trace_capture_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              stop,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [DATA_W-1:0] trigger_din,
  input  logic              trigger_en,
  input  logic [DATA_W-1:0] trace_din,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              trigger_out,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped,
  output logic              done
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("trace_capture_ctrl: DEPTH must be a power of two >= 4");
  end

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] post_left;
  logic [ADDR_W-1:0] cur_ptr;
  logic              restart;
  logic              write_now;
  logic              fire;
  logic              hit;
  state_t            after_hit;

  // The arm cycle is the first capture cycle: it samples into address 0,
  // which gives the one-cycle arm-to-first-write latency.
  assign restart   = arm && ((state == IDLE) || (state == DONE));
  assign cur_ptr   = restart ? '0 : wr_ptr;
  assign write_now = restart || (((state == ARMED) || (state == POST)) && !stop);
  assign hit       = fire && (restart || ((state == ARMED) && !stop));
  assign after_hit = (post_count == '0) ? DONE : POST;

  trace_trig_match #(.DATA_W(DATA_W)) u_match (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .trigger_en  (trigger_en),
    .trigger_din (trigger_din),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .fire        (fire)
  );

  // Capture FSM with registered RAM-side and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      post_left   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
      trigger_out <= 1'b0;
      trig_addr   <= '0;
      wrapped     <= 1'b0;
      done        <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      trigger_out <= 1'b0;

      if (restart) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        triggered <= 1'b0;
        wrapped   <= 1'b0;
      end

      if (write_now) begin
        wr_en   <= 1'b1;
        wr_addr <= cur_ptr;
        wr_data <= trace_din;
        wr_ptr  <= cur_ptr + 1'b1;
        if (cur_ptr == ADDR_W'(DEPTH - 1)) wrapped <= 1'b1;
      end

      // Only one trigger per capture; post_count is frozen here.
      if (hit) begin
        triggered   <= 1'b1;
        trigger_out <= 1'b1;
        trig_addr   <= cur_ptr;
        post_left   <= post_count;
      end

      case (state)
        IDLE: begin
          if (arm) state <= hit ? after_hit : ARMED;
        end
        ARMED: begin
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (hit) begin
            state <= after_hit;
          end
        end
        POST: begin
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            post_left <= post_left - 1'b1;
            if (post_left == ADDR_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          // done trails the final write strobe by one cycle.
          if (arm) begin
            state <= hit ? after_hit : ARMED;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: directed scenarios plus randomized traffic, each
// cycle compared against a behavioural capture model.
module tb_trace_capture_ctrl;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset, arm, stop, trigger_en;
  logic [DATA_W-1:0] trig_value, trig_mask, trigger_din, trace_din;
  logic [ADDR_W-1:0] post_count;
  logic              wr_en, busy, triggered, trigger_out, wrapped, done;
  logic [ADDR_W-1:0] wr_addr, trig_addr;
  logic [DATA_W-1:0] wr_data;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_tout = 0;

  // model state
  bit m_active, m_post, m_fin_pend, m_prev;
  int m_ptr, m_left;
  // model expected outputs
  bit e_wr_en, e_busy, e_trig, e_tout, e_wrapped, e_done;
  int e_addr, e_data, e_taddr;

  always #5 clk = ~clk;

  trace_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop),
    .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
    .trigger_din(trigger_din), .trigger_en(trigger_en), .trace_din(trace_din),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .triggered(triggered), .trigger_out(trigger_out), .trig_addr(trig_addr),
    .wrapped(wrapped), .done(done)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Capture rules applied to this cycle's inputs; yields next-cycle outputs.
  task automatic model();
    bit match, fire, start;
    match = trigger_en && (((trigger_din ^ trig_value) & trig_mask) == '0);
    if (reset) begin
      m_active = 0; m_post = 0; m_fin_pend = 0; m_prev = 0; m_ptr = 0; m_left = 0;
      e_wr_en = 0; e_busy = 0; e_trig = 0; e_tout = 0; e_wrapped = 0; e_done = 0;
      e_addr = 0; e_data = 0; e_taddr = 0;
      return;
    end
    start = arm && !m_active;
`ifdef TRACE_CAPTURE_CTRL_EDGE_EN
    fire = match && (start || !m_prev);
`else
    fire = match;
`endif
    e_wr_en = 0;
    e_tout  = 0;
    if (m_active && stop) begin
      m_active = 0; m_post = 0; e_busy = 0; e_done = 1;
    end else if (!m_active && m_fin_pend && !start) begin
      e_busy = 0; e_done = 1;
    end
    m_fin_pend = 0;
    if (start) begin
      m_active = 1; m_post = 0; m_ptr = 0;
      e_busy = 1; e_done = 0; e_trig = 0; e_wrapped = 0;
    end
    if (m_active) begin
      e_wr_en = 1; e_addr = m_ptr; e_data = int'(trace_din);
      if (m_ptr == DEPTH - 1) e_wrapped = 1;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_post) begin
        m_left--;
        if (m_left == 0) begin m_active = 0; m_post = 0; m_fin_pend = 1; end
      end else if (fire) begin
        e_trig = 1; e_tout = 1; e_taddr = e_addr;
        if (post_count == '0) begin m_active = 0; m_fin_pend = 1; end
        else begin m_post = 1; m_left = int'(post_count); end
      end
    end
    m_prev = match;
  endtask

  task automatic compare();
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("triggered", 32'(triggered), 32'(e_trig));
    chk("trigger_out", 32'(trigger_out), 32'(e_tout));
    chk("trig_addr", 32'(trig_addr), 32'(e_taddr));
    chk("wrapped", 32'(wrapped), 32'(e_wrapped));
    chk("done", 32'(done), 32'(e_done));
    if (wr_en) n_wr++;
    if (trigger_out) n_tout++;
  endtask

  task automatic step();
    model();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1; arm = 0; stop = 0; trigger_en = 0;
    trig_value = '0; trig_mask = '0; trigger_din = '0; trace_din = '0; post_count = '0;
    step(); step();
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    reset = 0;
    step();

    // counting buses, trigger at sample 5, three post samples
    trig_mask = 6'h3F; trig_value = 6'h05; post_count = 6'd3; trigger_en = 1;
    n_wr = 0; n_tout = 0;
    for (int i = 0; i < 14; i++) begin
      arm = (i == 0); trigger_din = DATA_W'(i); trace_din = DATA_W'(i);
      step();
    end
    arm = 0;
    chk("tp1_writes", 32'(n_wr), 32'd9);
    chk("tp1_pulses", 32'(n_tout), 32'd1);
    chk("tp1_taddr", 32'(trig_addr), 32'd5);
    chk("tp1_done", 32'(done), 32'd1);

    // long unmatched run wraps the pointer, then post_count 0 trigger
    trig_value = 6'h2A; post_count = 6'd0; trigger_en = 0; n_wr = 0;
    for (int i = 0; i < 70; i++) begin
      arm = (i == 0); trace_din = DATA_W'($urandom); trigger_din = DATA_W'($urandom);
      step();
    end
    arm = 0; trigger_en = 1; trigger_din = 6'h2A; trace_din = 6'h3C;
    step();
    trigger_en = 0;
    step(); step();
    chk("tp2_wrapped", 32'(wrapped), 32'd1);
    chk("tp2_writes", 32'(n_wr), 32'd71);
    chk("tp2_taddr", 32'(trig_addr), 32'd6);
    chk("tp2_done", 32'(done), 32'd1);

    // stop with two post samples outstanding
    trig_value = 6'h11; post_count = 6'd5; trigger_en = 1; trigger_din = '0; n_wr = 0;
    arm = 1; step(); arm = 0;
    step(); step();
    trigger_din = 6'h11; step(); trigger_din = '0;
    step(); step(); step();
    stop = 1; step(); stop = 0;
    step(); step();
    chk("tp3_writes", 32'(n_wr), 32'd7);
    chk("tp3_triggered", 32'(triggered), 32'd1);
    chk("tp3_done", 32'(done), 32'd1);

    // arm+stop together: from IDLE arms, from ARMED ends
    reset = 1; step(); reset = 0; trigger_en = 0;
    arm = 1; stop = 1; step();
    chk("tp4_busy", 32'(busy), 32'd1);
    step();
    arm = 0; stop = 0; step();
    chk("tp4_done", 32'(done), 32'd1);
    chk("tp4_idle", 32'(busy), 32'd0);

    // reset in the middle of POST
    trigger_en = 1; trigger_din = 6'h11; post_count = 6'd10;
    arm = 1; step(); arm = 0; trigger_din = '0;
    step(); step(); step();
    reset = 1; step(); reset = 0;
    chk("tp5_wr_en", 32'(wr_en), 32'd0);
    chk("tp5_trig", 32'(triggered), 32'd0);
    n_wr = 0;
    for (int i = 0; i < 5; i++) step();
    chk("tp5_no_writes", 32'(n_wr), 32'd0);

    // pattern held at level: only the first armed cycle triggers
    trigger_din = 6'h11; trigger_en = 1; post_count = 6'd4; n_tout = 0;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 11; i++) step();
    chk("tp6_pulses", 32'(n_tout), 32'd1);
    chk("tp6_taddr", 32'(trig_addr), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        trig_value = DATA_W'($urandom);
        trig_mask  = DATA_W'($urandom) & DATA_W'($urandom);
      end
      reset       = ($urandom_range(0, 399) == 0);
      arm         = ($urandom_range(0, 15) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      trigger_en  = ($urandom_range(0, 3) != 0);
      trigger_din = DATA_W'($urandom);
      trace_din   = DATA_W'($urandom);
      post_count  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
